scroll_addr_gen: RTL and testbench

Parametrised frame-buffer address generator for the VGA path. It converts the controller's h_cnt/v_cnt into a scaled image-memory address, with scroll offset, per-axis flip and selectable wrap or bounce scroll modes. It runs at variable speed and is driven by one-pulse keyboard commands. It sits between the keyboard command decode and the image block RAM. Its output is pipelined so the address arrives aligned with a registered valid.

---
 rtl/scroll_addr_gen.sv | 206 ++++++++++++++++++++
 tb/tb_scroll_addr_gen.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/scroll_addr_gen.sv
// Frame-buffer address generator: scroll offset, per-axis flip, wrap/bounce scroll modes and a
// two-stage pipelined, scaled image-memory address aligned with a registered valid.
module scroll_addr_gen #(
  parameter int unsigned SCR_W       = 640,
  parameter int unsigned SCR_H       = 480,
  parameter int unsigned IMG_W       = 320,
  parameter int unsigned SCALE_SHIFT = 1,
  parameter int unsigned ADDR_W      = 17,
  parameter int unsigned STEP_W      = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              step_en,
  input  logic [3:0]        cmd_dir,
  input  logic              cmd_pause,
  input  logic              cmd_mode,
  input  logic              cmd_flip_v,
  input  logic              cmd_flip_h,
  input  logic              cmd_speed_up,
  input  logic              cmd_speed_dn,
  input  logic [9:0]        h_cnt,
  input  logic [9:0]        v_cnt,
  input  logic              pix_valid,
  output logic [ADDR_W-1:0] pixel_addr,
  output logic              addr_valid,
  output logic [9:0]        pos_h,
  output logic [9:0]        pos_v,
  output logic [3:0]        dir,
  output logic              running,
  output logic [STEP_W-1:0] speed
);

  typedef enum logic [1:0] {StPaused, StWrap, StBounce} state_e;

  localparam logic [10:0]       LimW     = 11'(SCR_W);
  localparam logic [10:0]       LimH     = 11'(SCR_H);
  localparam logic [STEP_W-1:0] SpeedMax = {STEP_W{1'b1}};
  localparam logic [STEP_W-1:0] SpeedMin = STEP_W'(1);

  state_e            state_q, state_d;
  logic              saved_bounce_q, saved_bounce_d;
  logic [9:0]        pos_h_q, pos_h_d, pos_v_q, pos_v_d;
  logic [3:0]        dir_q, dir_d;
  logic [STEP_W-1:0] speed_q, speed_d;
  logic              flip_h_q, flip_h_d, flip_v_q, flip_v_d;
  logic [9:0]        hs_q, hs_d, vs_q, vs_d;
  logic              v1_q;
  logic [ADDR_W-1:0] pixel_addr_q, pixel_addr_d;
  logic              addr_valid_q;

  // Returns {reverse, new_pos} for one axis move of spd pixels.
  function automatic logic [10:0] axis_step(input logic [9:0] pos, input logic [10:0] spd,
                                            input logic inc, input logic bounce,
                                            input logic [10:0] lim);
    logic [10:0] p;
    logic [10:0] r;
    logic        rev;
    p   = {1'b0, pos};
    rev = 1'b0;
    if (inc) begin
      r = p + spd;
      if (bounce) begin
        if (r > lim - 11'd1) begin
          r   = lim - 11'd1;
          rev = 1'b1;
        end
      end else if (r >= lim) begin
        r = r - lim;
      end
    end else if (p < spd) begin
      if (bounce) begin
        r   = 11'd0;
        rev = 1'b1;
      end else begin
        r = p + lim - spd;
      end
    end else begin
      r = p - spd;
    end
    return {rev, r[9:0]};
  endfunction

  logic [10:0] spd_ext;
  logic [10:0] step_res;
  logic        bounce_now;
  logic        dir_cmd_ok;
  state_e      st_tmp;

  assign spd_ext    = 11'(speed_q);
  assign bounce_now = (state_q == StBounce);
  assign dir_cmd_ok = (cmd_dir != 4'd0) && ((cmd_dir & (cmd_dir - 4'd1)) == 4'd0);

  always_comb begin
    state_d        = state_q;
    saved_bounce_d = saved_bounce_q;
    pos_h_d        = pos_h_q;
    pos_v_d        = pos_v_q;
    dir_d          = dir_q;
    speed_d        = speed_q;
    flip_h_d       = flip_h_q ^ cmd_flip_h;
    flip_v_d       = flip_v_q ^ cmd_flip_v;
    step_res       = 11'd0;
    st_tmp         = state_q;

    // Mode toggle lands in saved_mode before the pause toggle reads it.
    if (cmd_mode) begin
      if (state_q == StPaused) begin
        saved_bounce_d = ~saved_bounce_q;
      end else begin
        st_tmp         = bounce_now ? StWrap : StBounce;
        saved_bounce_d = ~bounce_now;
      end
    end
    if (cmd_pause) begin
      if (st_tmp == StPaused) st_tmp = saved_bounce_d ? StBounce : StWrap;
      else                    st_tmp = StPaused;
    end
    state_d = st_tmp;

    if (cmd_speed_up && !cmd_speed_dn && speed_q != SpeedMax) speed_d = speed_q + SpeedMin;
    if (cmd_speed_dn && !cmd_speed_up && speed_q != SpeedMin) speed_d = speed_q - SpeedMin;

    if (step_en && state_q != StPaused) begin
      unique case (dir_q)
        4'b0001: begin
          step_res = axis_step(pos_v_q, spd_ext, 1'b1, bounce_now, LimH);
          pos_v_d  = step_res[9:0];
        end
        4'b0010: begin
          step_res = axis_step(pos_v_q, spd_ext, 1'b0, bounce_now, LimH);
          pos_v_d  = step_res[9:0];
        end
        4'b0100: begin
          step_res = axis_step(pos_h_q, spd_ext, 1'b1, bounce_now, LimW);
          pos_h_d  = step_res[9:0];
        end
        4'b1000: begin
          step_res = axis_step(pos_h_q, spd_ext, 1'b0, bounce_now, LimW);
          pos_h_d  = step_res[9:0];
        end
        default: step_res = 11'd0;
      endcase
      if (step_res[10]) dir_d = {dir_q[2], dir_q[3], dir_q[0], dir_q[1]};
    end
    if (dir_cmd_ok) dir_d = cmd_dir;
  end

  // Address pipeline
  logic [10:0] hsum, vsum;
  logic [31:0] addr_full;

  always_comb begin
    hsum = {1'b0, h_cnt} + {1'b0, pos_h_q};
    if (hsum >= LimW) hsum = hsum - LimW;
    if (flip_h_q) hsum = LimW - 11'd1 - hsum;
    vsum = {1'b0, v_cnt} + {1'b0, pos_v_q};
    if (vsum >= LimH) vsum = vsum - LimH;
    if (flip_v_q) vsum = LimH - 11'd1 - vsum;
    hs_d = hsum[9:0];
    vs_d = vsum[9:0];

    addr_full    = 32'(hs_q >> SCALE_SHIFT) + 32'(IMG_W) * 32'(vs_q >> SCALE_SHIFT);
    pixel_addr_d = v1_q ? addr_full[ADDR_W-1:0] : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= StPaused;
      saved_bounce_q <= 1'b0;
      pos_h_q        <= '0;
      pos_v_q        <= '0;
      dir_q          <= 4'b0001;
      speed_q        <= SpeedMin;
      flip_h_q       <= 1'b0;
      flip_v_q       <= 1'b0;
      hs_q           <= '0;
      vs_q           <= '0;
      v1_q           <= 1'b0;
      pixel_addr_q   <= '0;
      addr_valid_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      saved_bounce_q <= saved_bounce_d;
      pos_h_q        <= pos_h_d;
      pos_v_q        <= pos_v_d;
      dir_q          <= dir_d;
      speed_q        <= speed_d;
      flip_h_q       <= flip_h_d;
      flip_v_q       <= flip_v_d;
      hs_q           <= hs_d;
      vs_q           <= vs_d;
      v1_q           <= pix_valid;
      pixel_addr_q   <= pixel_addr_d;
      addr_valid_q   <= v1_q;
    end
  end

  assign pixel_addr = pixel_addr_q;
  assign addr_valid = addr_valid_q;
  assign pos_h      = pos_h_q;
  assign pos_v      = pos_v_q;
  assign dir        = dir_q;
  assign running    = (state_q != StPaused);
  assign speed      = speed_q;

endmodule

// File: tb/tb_scroll_addr_gen.sv
// Directed bench for scroll_addr_gen: hand-computed expectations for pipeline, scroll and FSM.
module tb_scroll_addr_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        step_en, cmd_pause, cmd_mode, cmd_flip_v, cmd_flip_h;
  logic        cmd_speed_up, cmd_speed_dn, pix_valid;
  logic [3:0]  cmd_dir;
  logic [9:0]  h_cnt, v_cnt;
  logic [16:0] pixel_addr;
  logic        addr_valid, running;
  logic [9:0]  pos_h, pos_v;
  logic [3:0]  dir;
  logic [3:0]  speed;

  int n_cmp = 0;
  int n_err = 0;

  scroll_addr_gen dut (
    .clk          (clk),
    .rst          (rst),
    .step_en      (step_en),
    .cmd_dir      (cmd_dir),
    .cmd_pause    (cmd_pause),
    .cmd_mode     (cmd_mode),
    .cmd_flip_v   (cmd_flip_v),
    .cmd_flip_h   (cmd_flip_h),
    .cmd_speed_up (cmd_speed_up),
    .cmd_speed_dn (cmd_speed_dn),
    .h_cnt        (h_cnt),
    .v_cnt        (v_cnt),
    .pix_valid    (pix_valid),
    .pixel_addr   (pixel_addr),
    .addr_valid   (addr_valid),
    .pos_h        (pos_h),
    .pos_v        (pos_v),
    .dir          (dir),
    .running      (running),
    .speed        (speed)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_dir(input logic [3:0] d);
    cmd_dir = d;
    tick();
    cmd_dir = 4'd0;
  endtask

  task automatic step();
    step_en = 1'b1;
    tick();
    step_en = 1'b0;
  endtask

  task automatic pause_pulse();
    cmd_pause = 1'b1;
    tick();
    cmd_pause = 1'b0;
  endtask

  task automatic speed_pulse(input logic up, input logic dn);
    cmd_speed_up = up;
    cmd_speed_dn = dn;
    tick();
    cmd_speed_up = 1'b0;
    cmd_speed_dn = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_pos_h"}, 32'(pos_h), 0);
    check_eq({tag, "_pos_v"}, 32'(pos_v), 0);
    check_eq({tag, "_dir"}, 32'(dir), 1);
    check_eq({tag, "_running"}, 32'(running), 0);
    check_eq({tag, "_speed"}, 32'(speed), 1);
    check_eq({tag, "_addr"}, 32'(pixel_addr), 0);
    check_eq({tag, "_valid"}, 32'(addr_valid), 0);
  endtask

  initial begin
    rst = 1'b0;
    step_en = 0; cmd_pause = 0; cmd_mode = 0; cmd_flip_v = 0; cmd_flip_h = 0;
    cmd_speed_up = 0; cmd_speed_dn = 0; pix_valid = 0; cmd_dir = 0; h_cnt = 0; v_cnt = 0;
    repeat (3) tick();
    check_reset_outputs("reset");
    rst = 1'b1;
    tick();

    // Pipeline latency: 5,3 -> 2 + 320*1
    h_cnt = 10'd5; v_cnt = 10'd3; pix_valid = 1'b1;
    tick();
    pix_valid = 1'b0;
    tick();
    check_eq("pipe_addr", 32'(pixel_addr), 322);
    check_eq("pipe_valid", 32'(addr_valid), 1);
    tick();
    check_eq("pipe_idle_addr", 32'(pixel_addr), 0);
    check_eq("pipe_idle_valid", 32'(addr_valid), 0);

    // Flips at origin
    cmd_flip_h = 1'b1; tick(); cmd_flip_h = 1'b0;
    h_cnt = 10'd0; v_cnt = 10'd0; pix_valid = 1'b1;
    tick(); tick();
    check_eq("flip_h_addr", 32'(pixel_addr), 319);
    cmd_flip_v = 1'b1; tick(); cmd_flip_v = 1'b0;
    tick(); tick();
    check_eq("flip_hv_addr", 32'(pixel_addr), 76799);
    cmd_flip_h = 1'b1; cmd_flip_v = 1'b1; tick(); cmd_flip_h = 1'b0; cmd_flip_v = 1'b0;
    tick(); tick();
    check_eq("unflip_addr", 32'(pixel_addr), 0);
    check_eq("unflip_valid", 32'(addr_valid), 1);
    pix_valid = 1'b0;

    // Paused: step has no effect
    step();
    check_eq("paused_pos_v", 32'(pos_v), 0);
    check_eq("paused_pos_h", 32'(pos_h), 0);

    // Speed saturation
    speed_pulse(1'b0, 1'b1);
    check_eq("speed_min_sat", 32'(speed), 1);
    repeat (20) speed_pulse(1'b1, 1'b0);
    check_eq("speed_max_sat", 32'(speed), 15);
    speed_pulse(1'b1, 1'b1);
    check_eq("speed_both", 32'(speed), 15);
    repeat (14) speed_pulse(1'b0, 1'b1);
    check_eq("speed_back_1", 32'(speed), 1);

    // WRAP mode
    pause_pulse();
    check_eq("run_wrap", 32'(running), 1);
    set_dir(4'b0010);
    check_eq("dir_down", 32'(dir), 4'b0010);
    step();
    check_eq("wrap_v_dec0", 32'(pos_v), 479);
    set_dir(4'b0001);
    step();
    check_eq("wrap_v_inc_top", 32'(pos_v), 0);
    step();
    check_eq("wrap_v_1", 32'(pos_v), 1);
    speed_pulse(1'b1, 1'b0);
    speed_pulse(1'b1, 1'b0);
    set_dir(4'b0010);
    step();
    check_eq("wrap_v_dec3", 32'(pos_v), 478);
    set_dir(4'b0110);
    check_eq("dir_multi_ignored", 32'(dir), 4'b0010);
    speed_pulse(1'b0, 1'b1);
    speed_pulse(1'b0, 1'b1);
    set_dir(4'b1000);
    step();
    check_eq("wrap_h_dec0", 32'(pos_h), 639);
    step();
    check_eq("wrap_h_638", 32'(pos_h), 638);
    speed_pulse(1'b1, 1'b0);
    speed_pulse(1'b1, 1'b0);
    set_dir(4'b0100);
    step();
    check_eq("wrap_h_inc3", 32'(pos_h), 1);

    // Offsets in the pipeline: h 5+1=6 -> 3, v 3+478=481 -> 1 -> 0
    h_cnt = 10'd5; v_cnt = 10'd3; pix_valid = 1'b1;
    tick();
    pix_valid = 1'b0;
    tick();
    check_eq("pipe_offset_addr", 32'(pixel_addr), 3);

    // BOUNCE mode
    cmd_mode = 1'b1; tick(); cmd_mode = 1'b0;
    check_eq("run_bounce", 32'(running), 1);
    set_dir(4'b0001);
    step();
    check_eq("bounce_clamp_v", 32'(pos_v), 479);
    check_eq("bounce_rev_dir", 32'(dir), 4'b0010);
    step();
    check_eq("bounce_dec", 32'(pos_v), 476);
    set_dir(4'b0001);
    step();
    check_eq("bounce_exact_top", 32'(pos_v), 479);
    check_eq("bounce_no_rev", 32'(dir), 4'b0001);
    step_en = 1'b1; cmd_dir = 4'b1000;
    tick();
    step_en = 1'b0; cmd_dir = 4'd0;
    check_eq("bounce_cmd_wins_dir", 32'(dir), 4'b1000);
    check_eq("bounce_cmd_wins_pos", 32'(pos_v), 479);

    // Async reset with the pipeline full
    h_cnt = 10'd100; v_cnt = 10'd50; pix_valid = 1'b1;
    tick(); tick();
    check_eq("full_valid", 32'(addr_valid), 1);
    rst = 1'b0;
    #2;
    check_reset_outputs("midrst");
    pix_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    pause_pulse();
    check_eq("rst_run", 32'(running), 1);
    set_dir(4'b0010);
    step();
    check_eq("rst_wrap_mode", 32'(pos_v), 479);

    // Pause and mode together: saved flips to BOUNCE, then pause
    cmd_pause = 1'b1; cmd_mode = 1'b1; tick(); cmd_pause = 1'b0; cmd_mode = 1'b0;
    check_eq("pm_paused", 32'(running), 0);
    pause_pulse();
    check_eq("pm_run", 32'(running), 1);
    set_dir(4'b0001);
    step();
    check_eq("pm_bounce_pos", 32'(pos_v), 479);
    check_eq("pm_bounce_dir", 32'(dir), 4'b0010);

    // Mode toggle while paused only changes saved mode
    pause_pulse();
    cmd_mode = 1'b1; tick(); cmd_mode = 1'b0;
    check_eq("pmode_paused", 32'(running), 0);
    pause_pulse();
    set_dir(4'b0001);
    step();
    check_eq("pmode_wrap_pos", 32'(pos_v), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
